// File: rtl/mac_neuron_seq_pkg.sv
// Shared types and constants for the MAC neuron sequencer: FSM encoding and MAC datapath geometry.
package mac_neuron_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StResult
  } state_e;

  localparam int unsigned MacLanes   = 16;
  localparam int unsigned MacLaneW   = 8;
  localparam int unsigned MacSumW    = 20;
  localparam int unsigned MacLatDef  = 3;
  localparam int unsigned NChunksDef = 49;

endpackage

// File: rtl/mac_neuron_seq_vld_pipe.sv
// mac_vld_pipe: Depth-stage valid shift register tracking reads in flight through memory + MAC.
module mac_vld_pipe #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vld_i,
  output logic vld_o,
  // High when the pipe will hold no valid bits after this edge.
  output logic idle_next_o
);

  logic [Depth-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = (pipe_q << 1) | Depth'(vld_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign vld_o       = pipe_q[Depth-1];
  assign idle_next_o = (pipe_d == '0);

endmodule

// File: rtl/mac_neuron_seq.sv
// Neuron sequencer: streams N_CHUNKS chunk reads into the MAC, accumulates sums onto a bias and
// returns the result over valid/ready. Define ACC_SAT_EN for saturating accumulation + acc_ovf.
module mac_neuron_seq
  import mac_neuron_seq_pkg::*;
#(
  parameter int unsigned N_CHUNKS = NChunksDef,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAC_LAT  = MacLatDef,
  parameter int unsigned ACC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ACC_W-1:0]   bias,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [MacSumW-1:0] mac_sum,
  output logic               busy,
  output logic [ACC_W-1:0]   result,
  output logic               result_valid,
`ifdef ACC_SAT_EN
  output logic               acc_ovf,
`endif
  input  logic               result_ready
);

  localparam int unsigned L    = MEM_LAT + MAC_LAT;
  localparam int unsigned CntW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CntW-1:0] LastChunk = CntW'(N_CHUNKS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              sum_vld;
  logic              pipe_idle_next;
  logic [ACC_W-1:0]  acc_add;
  logic              clamp;

  mac_vld_pipe #(
    .Depth(L)
  ) u_vld_pipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .vld_i      (rd_en),
    .vld_o      (sum_vld),
    .idle_next_o(pipe_idle_next)
  );

`ifdef ACC_SAT_EN
  logic [ACC_W:0] acc_sum;
  logic           ovf_q, ovf_d;

  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(mac_sum);
    clamp   = acc_sum[ACC_W];
    acc_add = clamp ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_add = acc_q + ACC_W'(mac_sum);
    clamp   = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
`ifdef ACC_SAT_EN
    ovf_d    = ovf_q | (sum_vld & clamp);
`endif
    if (sum_vld) begin
      acc_d = acc_add;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = '0;
          acc_d   = bias;
          state_d = StIssue;
`ifdef ACC_SAT_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StIssue: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastChunk) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave once the final sum lands in acc on this same edge.
        if (pipe_idle_next) begin
          result_d = acc_d;
          state_d  = StResult;
        end
      end
      StResult: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
`ifdef ACC_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
`ifdef ACC_SAT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign rd_en        = (state_q == StIssue);
  assign rd_addr      = addr_q;
  assign busy         = (state_q != StIdle);
  assign result       = result_q;
  assign result_valid = (state_q == StResult);
`ifdef ACC_SAT_EN
  assign acc_ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_mac_neuron_seq.sv
// Directed bench for mac_neuron_seq with a behavioural memory+MAC delay line feeding mac_sum.
module tb_mac_neuron_seq;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [31:0] bias;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [19:0] mac_sum;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  logic        rd_en_24;
  logic [9:0]  rd_addr_24;
  logic        busy_24;
  logic [23:0] result_24;
  logic        result_valid_24;

`ifdef ACC_SAT_EN
  logic acc_ovf;
  logic acc_ovf_24;
`endif

  logic [19:0] sum_const;
  logic [19:0] mpipe[L];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_neuron_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .bias        (bias),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .mac_sum     (mac_sum),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
`ifdef ACC_SAT_EN
    .acc_ovf     (acc_ovf),
`endif
    .result_ready(result_ready)
  );

  mac_neuron_seq #(
    .ACC_W(24)
  ) dut24 (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .bias        (bias[23:0]),
    .rd_en       (rd_en_24),
    .rd_addr     (rd_addr_24),
    .mac_sum     (mac_sum),
    .busy        (busy_24),
    .result      (result_24),
    .result_valid(result_valid_24),
`ifdef ACC_SAT_EN
    .acc_ovf     (acc_ovf_24),
`endif
    .result_ready(result_ready)
  );

  // Memory read + 3-stage MAC collapsed into an L-deep delay of the chunk sum.
  always @(posedge clk) begin
    mpipe[0] <= rd_en ? sum_const : 20'd0;
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mac_sum = mpipe[L-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_issue(input logic [9:0] base);
    for (int k = 0; k < 49; k++) begin
      logic [9:0] ea;
      ea = base + 10'(k);
      check("issue_rd_en", 64'(rd_en), 64'd1);
      check("issue_rd_addr", 64'(rd_addr), 64'(ea));
      @(negedge clk);
    end
    for (int c = 50; c < 54; c++) begin
      check("drain_rd_en", 64'(rd_en), 64'd0);
      check("drain_no_valid", 64'(result_valid), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bias = '0;
    result_ready = 1'b0;
    sum_const = '0;
    for (int i = 0; i < L; i++) mpipe[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal run: 49 * 1000 + 100.
    base_addr = 10'h040;
    bias = 32'd100;
    sum_const = 20'd1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("nom_busy", 64'(busy), 64'd1);
    check_issue(10'h040);
    check("nom_valid", 64'(result_valid), 64'd1);
    check("nom_result", 64'(result), 64'd49100);

    // Backpressure with start pulses that must be ignored.
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      base_addr = 10'h123;
      check("bp_valid", 64'(result_valid), 64'd1);
      check("bp_result", 64'(result), 64'd49100);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_rd_en", 64'(rd_en), 64'd0);
      @(negedge clk);
    end

    // Handshake with start held; start is honoured only the following cycle.
    result_ready = 1'b1;
    base_addr = 10'd1020;
    bias = 32'd0;
    sum_const = 20'hFFFFF;
    @(negedge clk);
    result_ready = 1'b0;
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_valid", 64'(result_valid), 64'd0);
    check("hs_rd_en", 64'(rd_en), 64'd0);
    check("hs_result_hold", 64'(result), 64'd49100);
    @(negedge clk);
    start = 1'b0;

    // Back-to-back run with wrapping addresses and max sums.
    check_issue(10'd1020);
    check("max_valid", 64'(result_valid), 64'd1);
    check("max_result", 64'(result), 64'd51380175);
`ifdef ACC_SAT_EN
    check("w24_result", 64'(result_24), 64'd16777215);
    check("w24_ovf", 64'(acc_ovf_24), 64'd1);
    check("w32_ovf", 64'(acc_ovf), 64'd0);
`else
    check("w24_result", 64'(result_24), 64'd1048527);
`endif
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("done_busy", 64'(busy), 64'd0);

    // Abort by reset while chunk 20 is being issued.
    base_addr = 10'd0;
    bias = 32'd5;
    sum_const = 20'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_addr", 64'(rd_addr), 64'd20);
    rst = 1'b1;
    #1;
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_rd_addr", 64'(rd_addr), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_valid", 64'(result_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      check("abort_no_result", 64'(result_valid | busy), 64'd0);
      @(negedge clk);
    end

    // Fresh run after abort: 7 + 49 * 3.
    base_addr = 10'd5;
    bias = 32'd7;
    sum_const = 20'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fresh_rd_en", 64'(rd_en), 64'd1);
    check("fresh_first_addr", 64'(rd_addr), 64'd5);
    repeat (48) @(negedge clk);
    check("fresh_last_addr", 64'(rd_addr), 64'd53);
    repeat (4) @(negedge clk);
    check("fresh_early", 64'(result_valid), 64'd0);
    @(negedge clk);
    check("fresh_valid", 64'(result_valid), 64'd1);
    check("fresh_result", 64'(result), 64'd154);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("fresh_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
